// File: rtl/risc_v_div_seq_pkg.sv
// Shared RV32M divide definitions: op codes and
// divider state encoding.
package risc_v_div_seq_pkg;

  localparam logic [1:0] DIV_OP  = 2'b00;
  localparam logic [1:0] DIVU_OP = 2'b01;
  localparam logic [1:0] REM_OP  = 2'b10;
  localparam logic [1:0] REMU_OP = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } div_state_t;

  // Two's-complement negation of a 32-bit word.
  function automatic logic [31:0] neg32(input logic [31:0] a);
    return ~a + 32'd1;
  endfunction

endpackage

// File: rtl/risc_v_div_seq.sv
// Sequential radix-2 restoring divider for
// RV32M DIV/DIVU/REM/REMU (32 iterations + fixup).
module risc_v_div_seq
  import risc_v_div_seq_pkg::*;
#(
  parameter PLATFORM = "XILINX"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd
);

  // Target family hook; both families share one datapath.
  if (PLATFORM == "XILINX") begin : g_xilinx
  end else begin : g_generic
  end

  div_state_t  r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_dvd;
  logic [31:0] r_div;
  logic [31:0] r_rem;
  logic        r_is_rem;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_rd;

  logic        w_s1;
  logic        w_s2;
  logic [31:0] w_a1;
  logic [31:0] w_a2;
  logic        w_dz;
  logic        w_ovf;
  logic [31:0] w_rem_sh;
  logic [32:0] w_diff;
  logic [31:0] w_q_res;
  logic [31:0] w_r_res;
  logic [31:0] w_res;

  // Operand signs/magnitudes and special-case detection.
  always_comb begin
    w_s1  = rs1[31] & ~op[0];
    w_s2  = rs2[31] & ~op[0];
    w_a1  = w_s1 ? neg32(rs1) : rs1;
    w_a2  = w_s2 ? neg32(rs2) : rs2;
    w_dz  = (rs2 == 32'd0);
    w_ovf = ~op[0]
          & (rs1 == 32'h8000_0000)
          & (rs2 == 32'hFFFF_FFFF);
  end

  // One restoring step; quotient bits enter dvd's LSB.
  always_comb begin
    w_rem_sh = {r_rem[30:0], r_dvd[31]};
    w_diff   = {1'b0, w_rem_sh} - {1'b0, r_div};
  end

  // Sign correction and result selection.
  always_comb begin
    w_q_res = r_neg_q ? neg32(r_dvd) : r_dvd;
    w_r_res = r_neg_r ? neg32(r_rem) : r_rem;
    w_res   = r_is_rem ? w_r_res : w_q_res;
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 5'd0;
      r_dvd    <= 32'd0;
      r_div    <= 32'd0;
      r_rem    <= 32'd0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rd     <= 32'd0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_is_rem <= op[1];
            r_cnt    <= 5'd0;
            r_div    <= w_a2;
            r_busy   <= 1'b1;
            if (w_dz) begin
              // Quotient all ones, remainder = dividend.
              r_dvd   <= 32'hFFFF_FFFF;
              r_rem   <= rs1;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= FIXUP;
            end else if (w_ovf) begin
              r_dvd   <= 32'h8000_0000;
              r_rem   <= 32'd0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= FIXUP;
            end else begin
              r_dvd   <= w_a1;
              r_rem   <= 32'd0;
              r_neg_q <= w_s1 ^ w_s2;
              r_neg_r <= w_s1;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (w_diff[32]) begin
            r_rem <= w_rem_sh;
          end else begin
            r_rem <= w_diff[31:0];
          end
          r_dvd <= {r_dvd[30:0], ~w_diff[32]};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= FIXUP;
          end
        end
        FIXUP: begin
          r_rd    <= w_res;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign rd   = r_rd;

endmodule

// File: tb/tb_risc_v_div_seq.sv
// Randomized self-checking bench for risc_v_div_seq
// against an arithmetic RV32M reference model.
module tb_risc_v_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] rd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  risc_v_div_seq #(.PLATFORM("XILINX")) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .rs1   (rs1),
    .rs2   (rs2),
    .busy  (busy),
    .done  (done),
    .rd    (rd)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(
    input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (o)
      2'b00: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      2'b01: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      2'b10: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return sa % sb;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_fast(
    input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) ||
           (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // One request; optionally pokes a start mid-CALC.
  task automatic run_op(input logic [1:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input bit poke,
                        input string tag);
    int k;
    logic [31:0] exp;
    exp = ref_model(o, a, b);
    @(negedge clk);
    start = 1'b1;
    op = o;
    rs1 = a;
    rs2 = b;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom);
    rs1 = $urandom;
    rs2 = $urandom;
    chk({tag, "/busy"}, 32'(busy), 32'd1);
    k = 0;
    while (!done && k < 40) begin
      start = poke && (k == 5);
      if (start) begin
        op = 2'($urandom);
        rs1 = $urandom;
        rs2 = $urandom_range(1, 9);
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk({tag, "/lat"}, 32'(k), is_fast(o, a, b) ? 32'd1 : 32'd33);
    chk({tag, "/rd"}, rd, exp);
    chk({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "/pulse"}, 32'(done), 32'd0);
    chk({tag, "/hold"}, rd, exp);
  endtask

  logic [1:0]  bo[40];
  logic [31:0] ba[40];
  logic [31:0] bb[40];
  int accq[$];

  initial begin
    int next_free;
    int dones;
    int exp_dones;
    int a_idx;
    logic [1:0] ro;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    rs1 = 32'd0;
    rs2 = 32'd0;
    #1;
    chk("reset/busy", 32'(busy), 32'd0);
    chk("reset/done", 32'(done), 32'd0);
    chk("reset/rd", rd, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(2'b01, 32'd100, 32'd7, 1'b0, "divu100_7");
    run_op(2'b11, 32'd100, 32'd7, 1'b0, "remu100_7");
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0, "div-7_2");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "rem-7_2");
    run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 1'b0, "div7_-2");
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, "rem7_-2");
    run_op(2'b01, 32'd5, 32'd0, 1'b0, "divu_by0");
    run_op(2'b10, 32'h8000_0001, 32'd0, 1'b0, "rem_by0");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divu_big");
    run_op(2'b01, 32'd1000, 32'd3, 1'b1, "poke_mid_calc");

    // Random mix, biased toward edge operands.
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        3: rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: ;
      endcase
      run_op(ro, ra, rb, 1'b0, "rand");
    end

    // start held high with changing operands.
    next_free = 0;
    dones = 0;
    exp_dones = 0;
    for (int j = 0; j < 90; j++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (accq.size() == 0) begin
          chk("b2b/spurious_done", 32'd1, 32'd0);
        end else begin
          a_idx = accq.pop_front();
          chk("b2b/rd", rd, ref_model(bo[a_idx], ba[a_idx], bb[a_idx]));
          chk("b2b/lat", 32'(j - a_idx),
              is_fast(bo[a_idx], ba[a_idx], bb[a_idx]) ? 32'd2 : 32'd34);
        end
      end
      if (j < 40) begin
        bo[j] = 2'($urandom);
        ba[j] = $urandom;
        bb[j] = $urandom_range(1, 32'hFFFF);
        start = 1'b1;
        op = bo[j];
        rs1 = ba[j];
        rs2 = bb[j];
        if (j >= next_free) begin
          accq.push_back(j);
          next_free = j + (is_fast(bo[j], ba[j], bb[j]) ? 2 : 34);
          exp_dones++;
        end
      end else begin
        start = 1'b0;
      end
    end
    chk("b2b/count", 32'(dones), 32'(exp_dones));

    // Asynchronous reset in the middle of CALC.
    run_op(2'b01, 32'd99, 32'd4, 1'b0, "pre_reset");
    @(negedge clk);
    start = 1'b1;
    op = 2'b01;
    rs1 = 32'd1000;
    rs2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("midreset/busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midreset/busy", 32'(busy), 32'd0);
    chk("midreset/done", 32'(done), 32'd0);
    chk("midreset/rd", rd, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midreset/no_done", 32'(dones), 32'd0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/risc_v_div_seq.md
Name: risc_v_div_seq

Overview:
Sequential radix-2 restoring divider implementing the RV32M DIV, DIVU, REM and REMU instructions. It is the responder side of the ALU's divide path. The ALU decodes the instruction and issues a start request with operands and op. This block iterates and returns a registered result with a done pulse. It replaces the combinational 64-bit divide for timing-constrained builds.

Parameters:
PLATFORM, "XILINX", target family string; no behavioural effect, kept for integration consistency.

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request strobe; sampled only in IDLE
op  in  2  instruction funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
rs1  in  32  dividend; sampled with start
rs2  in  32  divisor; sampled with start
busy  out  1  high while a request is in progress (CALC or FIXUP)
done  out  1  one-cycle pulse; rd valid from this cycle
rd  out  32  result; holds its value until the next accepted start completes

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, rd=0, counter=0, internal regs=0. Reset mid-operation discards the request; no done is produced.
- States: IDLE, CALC, FIXUP.
  - IDLE→CALC on start, normal case.
  - IDLE→FIXUP on start, special case.
  - CALC→FIXUP after the 32nd iteration.
  - FIXUP→IDLE unconditionally.
- Accept: start=1 in IDLE at edge N latches op, operand signs, |rs1|, |rs2|, quotient=0, remainder=0 and count=0.
  - Magnitudes are taken only for signed ops (op[0]=0).
- CALC, one iteration per edge at N+1..N+32:
  - rem_shift = {rem[30:0], dvd[31]}; dvd shifts left by 1.
  - diff = {1'b0,rem_shift} − {1'b0,div} (33 bits).
  - If diff[32]=0: rem=diff[31:0] and the quotient LSB is set to 1. Otherwise rem=rem_shift and the LSB is 0.
  - The quotient shares the dvd shift register.
- FIXUP (edge N+33): selects the result and registers it into rd; done=1 for exactly one cycle; busy=0 in that same cycle.
  - DIV: negate the quotient if sign(rs1)≠sign(rs2).
  - REM: negate the remainder if sign(rs1)=1.
  - DIVU/REMU: raw quotient/remainder.
- Latency, normal case: 33 cycles from the start edge to done. busy is high for cycles N+1..N+33 edges (32 CALC + 1 FIXUP).
- Special cases are detected at accept and go straight to FIXUP; done comes after edge N+1:
  - rs2=0: DIV/DIVU rd=0xFFFFFFFF; REM/REMU rd=rs1.
  - DIV, rs1=0x80000000, rs2=0xFFFFFFFF: rd=0x80000000; REM with the same operands: rd=0.
- start while busy is ignored, with no queueing. start in the cycle done is high is accepted, because the state is already IDLE.
- Operands must be stable only in the start cycle; later changes on rs1/rs2/op have no effect.
- rd changes only at FIXUP and is otherwise stable; done never asserts without a preceding accepted start.

Decomposition:
- Shared header (the ALU instruction-definition include):
  - op codes as localparams: DIV_OP=2'b00, DIVU_OP=2'b01, REM_OP=2'b10, REMU_OP=2'b11.
  - State encodings: IDLE=2'd0, CALC=2'd1, FIXUP=2'd2.
- Single module. The iteration step stays inline; no sub-module is warranted at this size.

Test Plan:
- DIVU 100/7: start, op=01, rs1=100, rs2=7 → done exactly 33 cycles later, rd=14; REMU same operands → rd=2.
- Signed: DIV −7/2 (0xFFFFFFF9, 2) → rd=0xFFFFFFFD; REM same → rd=0xFFFFFFFF; DIV 7/−2 → rd=0xFFFFFFFD, REM → rd=1.
- Divide by zero: DIVU 5/0 → done 1 cycle after start, rd=0xFFFFFFFF; REM 0x80000001/0 → rd=0x80000001.
- Overflow: DIV 0x80000000/0xFFFFFFFF → rd=0x80000000, fast path; REM same → rd=0.
- Handshake: start held high for 40 cycles with changing operands → one result per 34 cycles (back-to-back acceptance in the done cycle); a start pulse mid-CALC is ignored and rd is unaffected.
- Reset: assert rst at CALC iteration 10 → busy=0, done=0, rd=0 immediately (async); no done follows. A new DIVU 0xFFFFFFFF/1 after release → rd=0xFFFFFFFF.
